// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - parametrised 1W/2R register file with registered reads; optional write-first bypass via RF_BYPASS_EN
module reg_file_mp #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 5,
  parameter int ZERO_REG0 = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd1_en,
  input  logic [ADDR_W-1:0] rd1_addr,
  input  logic              rd2_en,
  input  logic [ADDR_W-1:0] rd2_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd1_data,
  output logic              rd1_valid,
  output logic [DATA_W-1:0] rd2_data,
  output logic              rd2_valid
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_to_zero;
  logic              wr_fire;
  logic [DATA_W-1:0] rd1_next;
  logic [DATA_W-1:0] rd2_next;

  // A write aimed at the hard-wired zero entry is discarded before it reaches storage
  // or the bypass path, so the zero entry can never leak a written value.
  assign wr_to_zero = (ZERO_REG0 != 0) && (wr_addr == '0);
  assign wr_fire    = wr_en && !wr_to_zero;

  // Storage array: cleared asynchronously, one write per edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_fire) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Port 1 source: stored word, optionally overridden by same-edge write data, forced to 0 for the zero entry.
  always_comb begin
    rd1_next = mem[rd1_addr];
`ifdef RF_BYPASS_EN
    if (wr_fire && (wr_addr == rd1_addr)) begin
      rd1_next = wr_data;
    end
`endif
    if ((ZERO_REG0 != 0) && (rd1_addr == '0)) begin
      rd1_next = '0;
    end
  end

  // Port 2 source: same selection rules as port 1, fully independent address.
  always_comb begin
    rd2_next = mem[rd2_addr];
`ifdef RF_BYPASS_EN
    if (wr_fire && (wr_addr == rd2_addr)) begin
      rd2_next = wr_data;
    end
`endif
    if ((ZERO_REG0 != 0) && (rd2_addr == '0)) begin
      rd2_next = '0;
    end
  end

  // Port 1 output register: data loads only on a request, valid pulses for one cycle per request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd1_data  <= '0;
      rd1_valid <= 1'b0;
    end else begin
      rd1_valid <= rd1_en;
      if (rd1_en) begin
        rd1_data <= rd1_next;
      end
    end
  end

  // Port 2 output register: data loads only on a request, valid pulses for one cycle per request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd2_data  <= '0;
      rd2_valid <= 1'b0;
    end else begin
      rd2_valid <= rd2_en;
      if (rd2_en) begin
        rd2_data <= rd2_next;
      end
    end
  end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port register file for the 16-bit datapath: one write port and two independent read ports with registered outputs and per-port valid flags. It is the generalised successor of the fixed 32×16 register file, sitting between instruction decode (read addresses) and writeback (write port). It adds configurable width and depth, asynchronous clear of all state, an optional hard-wired zero register, and compile-time write-to-read bypass.

## Interface
- DATA_W, 16, width of each register and data port
- ADDR_W, 5, address width; depth = 2**ADDR_W entries
- ZERO_REG0, 0, when 1 entry 0 always reads 0 and ignores writes

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- rd1_en  in  1  read request, port 1
- rd1_addr  in  ADDR_W  read address, port 1
- rd2_en  in  1  read request, port 2
- rd2_addr  in  ADDR_W  read address, port 2
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rd1_data  out  DATA_W  registered read data, port 1
- rd1_valid  out  1  rd1_data updated by the read issued last cycle
- rd2_data  out  DATA_W  registered read data, port 2
- rd2_valid  out  1  rd2_data updated by the read issued last cycle

## Operation
- Storage: 2**ADDR_W entries of DATA_W bits, implemented in flops (async clear required).
- Reset (rst=1, any time, no clock needed): every entry = 0, rd1_data = rd2_data = 0, rd1_valid = rd2_valid = 0. Held while rst=1; a read or write in progress is abandoned.
- Write: wr_en=1 at edge -> entry[wr_addr] <= wr_data. If ZERO_REG0=1 and wr_addr=0, write is dropped.
- Read port n: rdn_en=1 at edge -> rdn_data <= entry[rdn_addr], rdn_valid <= 1. rdn_en=0 -> rdn_data holds last value, rdn_valid <= 0.
- Ports are fully independent; both read ports may address the same entry, any combination of enables is legal in one cycle.
- ZERO_REG0=1: read of address 0 returns 0 regardless of storage.
- Same-cycle read and write of same address: result set by RF_BYPASS_EN (see Configuration). Writes to different addresses never affect a concurrent read.
- Addresses are always in range (full 2**ADDR_W decode); no wrap or error condition exists.

## Timing
- Write latency: value visible to a read issued in the cycle after the write edge (1 cycle), or same cycle when bypass is enabled.
- Read latency: 1 cycle; rdn_data/rdn_valid change only on the edge sampling rdn_en=1.
- rdn_valid is a single-cycle pulse per request; back-to-back requests give continuous valid with new data each cycle.
- No zero-delay or #-delay assignments; all timing is edge-defined.
- rst deassertion: first edge with rst=0 may perform read/write normally.

## Configuration
- Macro RF_BYPASS_EN.
- Defined: same-edge read of wr_addr while wr_en=1 returns wr_data (write-first). With ZERO_REG0=1 and address 0, result stays 0.
- Undefined: same-edge read returns the old entry value (read-first); new value visible from next read.

## Test plan
- Reset: write 0xBEEF to entry 7, assert rst mid-cycle -> rd*_data=0, rd*_valid=0 immediately; read entry 7 after release -> 0x0000, valid=1 one cycle later.
- Basic R/W: write 0x1234 to 3, 0xABCD to 31; next cycle read port1=3, port2=31 -> next edge rd1_data=0x1234, rd2_data=0xABCD, both valid=1; following idle cycle valid=0, data held.
- Collision: entry 5 = 0x1111; same edge write 0x2222 to 5 and read 5 on both ports -> 0x2222 with RF_BYPASS_EN, 0x1111 without; next read -> 0x2222 in both builds.
- Zero register: ZERO_REG0=1, write 0xFFFF to 0, read 0 -> 0x0000; ZERO_REG0=0 same sequence -> 0xFFFF.
- Parametrisation: DATA_W=32, ADDR_W=3; write 0xDEADBEEF to 7, read 7 -> 0xDEADBEEF; write all 8 entries with index, read back all via both ports -> matching values.
- Back-to-back: read ports 1 and 2 issue 8 consecutive reads of entries 0..7 -> rdn_valid high 8 consecutive cycles, data sequence 0..7 (after prefill).
